// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Bundles the serial line and the byte-side outputs of the UART receiver so
//   the receiver and whatever drives its line / consumes its bytes share one
//   port.
//
//   Signals
//     rx_in       serial line into the receiver (asynchronous to clk)
//     data_out    last correctly received byte
//     data_valid  1-cycle pulse: data_out updated this cycle
//     frame_err   1-cycle pulse: stop bit sampled low
//     rx_busy     receiver is inside a frame (FSM not idle)
//
//   Modports
//     slave   receiver side: consumes rx_in, produces the byte-side outputs
//     master  environment side: drives rx_in, observes the byte-side outputs
// -----------------------------------------------------------------------------
interface uart_rx_if;
   logic       rx_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       rx_busy;

   modport slave (
      input  rx_in,
      output data_out,
      output data_valid,
      output frame_err,
      output rx_busy
   );

   modport master (
      output rx_in,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  rx_busy
   );
endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first,
//   1 stop bit (1); the line idles high. The asynchronous line is brought into
//   the clk domain by a two-flop synchroniser; the FSM works only on the
//   synchronised copy. The start bit is re-checked at its centre to reject
//   glitches, then every following bit is sampled one bit period later, i.e.
//   at its centre. Each completed frame produces exactly one 1-cycle pulse:
//   data_valid for a good stop bit, frame_err for a low stop bit.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per serial bit; must be even and >= 4
//
//   Ports
//     clk    in   system clock, all state on the rising edge
//     rst_n  in   asynchronous reset, active-low
//     rx     uart_rx_if.slave
//              rx_in       in   serial line (asynchronous)
//              data_out    out  last correctly received byte
//              data_valid  out  1-cycle pulse, data_out updated this cycle
//              frame_err   out  1-cycle pulse, stop bit sampled low
//              rx_busy     out  high whenever the FSM is not IDLE
//
//   Latency: if edge N is the first clk edge that samples rx_in low, the
//   start check is at edge N+2+HALF, data bit k is sampled at edge
//   N+2+HALF+(k+1)*CLKS_PER_BIT and the result pulse is high in the cycle
//   after edge N+2+HALF+9*CLKS_PER_BIT.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave rx
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   // Terminal counts: cnt stops at these values and is cleared, so it never
   // wraps and CNT_W bits are always enough.
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           state_q,      state_d;
   logic [1:0]       sync_q,       sync_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic [2:0]       bit_idx_q,    bit_idx_d;
   logic [7:0]       shift_q,      shift_d;
   logic [7:0]       data_q,       data_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q,  frame_err_d;

   // Synchronised line: sync_q[0] may go metastable, sync_q[1] is the only
   // copy the FSM is allowed to look at.
   logic rx_s;
   assign rx_s = sync_q[1];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d signal gets a default before the case so that no path
      // leaves one unassigned; a missing default here would infer a latch.
      state_d      = state_q;
      sync_d       = {sync_q[0], rx.rx_in};
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (cnt_q == CNT_HALF_END) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  // Line went back high before mid-bit: a glitch, not a frame.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d       = shift_q;
                  data_valid_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  // data_out keeps the last good byte; a bad frame never
                  // overwrites it.
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HI;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_HI: begin
            // A held-low line (break) must not be read as a string of start
            // bits, so wait for the line to return high before re-arming.
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchroniser resets to the idle line level so reset release never
         // looks like a start bit.
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed from the previous state, independent of statement order.
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rx.data_out   = data_q;
   assign rx.data_valid = data_valid_q;
   assign rx.frame_err  = frame_err_q;
   assign rx.rx_busy    = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed and randomised frames for uart_rx. Each frame is built as a list
//   of per-clock line levels; a reference model reads that list at the
//   receiver's sampling points (mid start bit, then one bit period apart) to
//   predict the byte, the pulse type and the cycle of the pulse. A monitor
//   logs every pulse the DUT emits and the log is compared with the
//   predictions.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB     = 16;
   localparam int HALF    = CPB / 2;
   localparam int LATENCY = 2 + HALF + 9 * CPB;   // first-low edge -> pulse

   logic clk = 1'b0;
   logic rst_n;

   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       dv;
      logic       fe;
      logic [7:0] data;
      logic       busy;
   } pulse_t;

   pulse_t     obs_q[$];
   pulse_t     exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_data;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      if (bus.data_valid || bus.frame_err)
         obs_q.push_back('{cyc, bus.data_valid, bus.frame_err, bus.data_out, bus.rx_busy});
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: run did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic line_at(input logic w[$], input int idx);
      return (idx < w.size()) ? w[idx] : 1'b1;   // line idles high afterwards
   endfunction

   task automatic hold(input logic level, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.rx_in = level;
      end
   endtask

   // Drive one frame with the given bit period. abort_at >= 0 pulses rst_n at
   // that clock of the frame and abandons the rest of it.
   task automatic send(input logic [7:0] b, input int per, input logic stop_bit,
                       input int abort_at);
      logic       wave[$];
      logic [7:0] got;
      int         t0;
      t0 = 0;
      for (int i = 0; i < 10 * per; i++) begin
         int slot;
         slot = i / per;
         if (slot == 0)      wave.push_back(1'b0);
         else if (slot == 9) wave.push_back(stop_bit);
         else                wave.push_back(b[slot-1]);
      end
      for (int i = 0; i < wave.size(); i++) begin
         @(negedge clk);
         if (i == 0) t0 = cyc + 1;
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort.data_out",   32'(bus.data_out),   32'h0);
            check("abort.data_valid", 32'(bus.data_valid), 32'h0);
            check("abort.frame_err",  32'(bus.frame_err),  32'h0);
            check("abort.rx_busy",    32'(bus.rx_busy),    32'h0);
            bus.rx_in = 1'b1;
            repeat (2) @(negedge clk);
            rst_n      = 1'b1;
            model_data = 8'h00;
            return;
         end
         bus.rx_in = wave[i];
      end
      // Reference model: wave[j] is what the receiver's input sampled j edges
      // after the first low edge.
      if (line_at(wave, HALF) == 1'b0) begin
         for (int k = 0; k < 8; k++) got[k] = line_at(wave, HALF + (k + 1) * CPB);
         if (line_at(wave, HALF + 9 * CPB)) begin
            model_data = got;
            exp_q.push_back('{t0 + LATENCY, 1'b1, 1'b0, got, 1'b0});
         end else begin
            exp_q.push_back('{t0 + LATENCY, 1'b0, 1'b1, model_data, 1'b1});
         end
      end
   endtask

   task automatic check_pulses(input string tag);
      pulse_t o;
      pulse_t e;
      check({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, ".cycle"},      32'(o.cyc),  32'(e.cyc));
         check({tag, ".data_valid"}, 32'(o.dv),   32'(e.dv));
         check({tag, ".frame_err"},  32'(o.fe),   32'(e.fe));
         check({tag, ".data_out"},   32'(o.data), 32'(e.data));
         check({tag, ".rx_busy"},    32'(o.busy), 32'(e.busy));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int         gap;
      logic [7:0] rb;
      logic       bad;

      // Reset state
      rst_n      = 1'b0;
      bus.rx_in  = 1'b1;
      model_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset.data_out",   32'(bus.data_out),   32'h0);
      check("reset.data_valid", 32'(bus.data_valid), 32'h0);
      check("reset.frame_err",  32'(bus.frame_err),  32'h0);
      check("reset.rx_busy",    32'(bus.rx_busy),    32'h0);
      rst_n = 1'b1;
      hold(1'b1, 10);

      // Single frame
      send(8'hA5, CPB, 1'b1, -1);
      hold(1'b1, 12);
      check_pulses("single");
      check("single.byte", 32'(bus.data_out), 32'hA5);

      // Back-to-back frames, no idle gap
      send(8'h00, CPB, 1'b1, -1);
      send(8'hFF, CPB, 1'b1, -1);
      hold(1'b1, 12);
      check_pulses("b2b");
      check("b2b.byte", 32'(bus.data_out), 32'hFF);

      // Short low glitch must be rejected, then a normal frame
      hold(1'b0, 4);
      hold(1'b1, 20);
      check_pulses("glitch");
      check("glitch.rx_busy", 32'(bus.rx_busy), 32'h0);
      send(8'h3C, CPB, 1'b1, -1);
      hold(1'b1, 12);
      check_pulses("post_glitch");

      // Low stop bit followed by a long break, then recovery
      send(8'h55, CPB, 1'b0, -1);
      hold(1'b0, 500);
      check("break.rx_busy", 32'(bus.rx_busy), 32'h1);
      hold(1'b1, 10);
      check("break_end.rx_busy", 32'(bus.rx_busy), 32'h0);
      check_pulses("break");
      check("break.byte_kept", 32'(bus.data_out), 32'h3C);
      send(8'h81, CPB, 1'b1, -1);
      hold(1'b1, 12);
      check_pulses("post_break");

      // Reset in the middle of data bit 4
      send(8'h5A, CPB, 1'b1, 5 * CPB + HALF);
      hold(1'b1, 20);
      check_pulses("abort");
      send(8'hC3, CPB, 1'b1, -1);
      hold(1'b1, 12);
      check_pulses("post_abort");
      check("post_abort.byte", 32'(bus.data_out), 32'hC3);

      // Transmitter clock off by about -6% and +6%. The model reads the line at
      // the receiver's fixed 16-clk sampling grid, so it predicts whatever byte
      // that grid lands on for each period.
      send(8'h96, 15, 1'b1, -1);
      hold(1'b1, 20);
      check_pulses("slow_rx");
      send(8'h96, 17, 1'b1, -1);
      hold(1'b1, 20);
      check_pulses("fast_rx");
      check("fast_rx.byte", 32'(bus.data_out), 32'h96);

      // Random bytes, random stop-bit errors, random idle gaps
      for (int r = 0; r < 12; r++) begin
         rb  = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         send(rb, CPB, !bad, -1);
         gap = bad ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 20));
         hold(1'b1, gap);
      end
      hold(1'b1, 12);
      check_pulses("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx
